// File: rtl/ws_sram_writer.sv
// ws_sram_writer
//   Write-back stage for one 8x8 IDCT block. Reads the 64 signed S values
//   from DPRAM0, clips each to 8 bits and writes 32 packed words
//   {even pixel, odd pixel} into the block's place in the output frame
//   in SRAM. The block position (plane, block row RB, block column CB) is
//   tracked internally and advances after every completed block:
//   Y (40x30 blocks) -> U (20x30) -> V (20x30) -> Y of the next frame.
//
// Handshake: WS_start is a request sampled only in S_WS_IDLE. WS_done is
//   a one-cycle completion pulse. There is no back-pressure: once started,
//   a block runs to completion in 67 cycles unless Resetn aborts it.
//
// Ports
//   CLOCK_50_I       system clock
//   Resetn           asynchronous active-low reset
//   WS_start         start one block (IDLE only)
//   WS_done          one-cycle pulse, block fully written
//   WS_read_address  DPRAM0 read address (combinational, DP_BASE+SC)
//   WS_read_data     DPRAM0 read data, valid one cycle after the address
//   SRAM_address     registered SRAM word address
//   SRAM_write_data  registered {clip(S[2j]), clip(S[2j+1])}
//   SRAM_we_n        registered active-low write enable
//   WS_clip_count    (only with WS_CLIP_CNT_EN) saturating count of
//                    S values that were altered by clipping
//
// Build option: define WS_CLIP_CNT_EN to add the clip counter.
module ws_sram_writer #(
  parameter logic [17:0] Y_BASE  = 18'd0,
  parameter logic [17:0] U_BASE  = 18'd38400,
  parameter logic [17:0] V_BASE  = 18'd57600,
  parameter logic [6:0]  DP_BASE = 7'd0
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WS_start,
  output logic        WS_done,
  output logic [6:0]  WS_read_address,
  input  logic [31:0] WS_read_data,
`ifdef WS_CLIP_CNT_EN
  output logic [15:0] WS_clip_count,
`endif
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [2:0] {
    S_WS_IDLE, S_WS_RD_EVEN, S_WS_RD_ODD, S_WS_LO, S_WS_DONE
  } ws_state_t;

  localparam logic [1:0] PL_Y = 2'd0;
  localparam logic [1:0] PL_U = 2'd1;
  localparam logic [1:0] PL_V = 2'd2;

  ws_state_t   state, state_n;
  logic [5:0]  sc;          // sample counter, index of S being addressed
  logic [7:0]  even_pix;    // clipped even sample of the pair in flight
  logic [4:0]  pair_idx;    // j of the pair in flight
  logic        pend;        // a pair's odd sample arrives this cycle
  logic [1:0]  plane;
  logic [4:0]  rb;
  logic [5:0]  cb;
  logic [5:0]  c_end;

  logic [7:0]  cur_pix;
  logic        cur_clipped;
  logic        wr_issue;
  logic [17:0] plane_base;
  logic [17:0] row18;
  logic [17:0] row_off;
  logic [17:0] wr_addr;

  logic        we_n_n, done_n;
  logic [17:0] addr_n;
  logic [15:0] data_n;

  function automatic logic [7:0] clip8(input logic [31:0] s);
    if (s[31])           return 8'h00;
    else if (|s[30:8])   return 8'hFF;
    else                 return s[7:0];
  endfunction

  assign WS_read_address = DP_BASE + {1'b0, sc};
  assign c_end           = (plane == PL_Y) ? 6'd39 : 6'd19;

  // Datapath: clip the sample on the read bus and form the write address.
  always_comb begin
    cur_pix     = clip8(WS_read_data);
    // Any clip alters the value: negatives become 0, >255 become 255.
    cur_clipped = WS_read_data[31] | (|WS_read_data[30:8]);
    wr_issue    = ((state == S_WS_RD_EVEN) && pend) || (state == S_WS_LO);
    case (plane)
      PL_U:    plane_base = U_BASE;
      PL_V:    plane_base = V_BASE;
      default: plane_base = Y_BASE;
    endcase
    // Frame row = RB*8 + pair row; row width is 160 words (Y) or 80 (U/V).
    row18 = {10'd0, rb, pair_idx[4:2]};
    if (plane == PL_Y) row_off = (row18 << 7) + (row18 << 5);
    else               row_off = (row18 << 6) + (row18 << 4);
    wr_addr = plane_base + row_off + {10'd0, cb, pair_idx[1:0]};
  end

  // FSM: state register
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state <= S_WS_IDLE;
    else         state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      S_WS_IDLE:    if (WS_start) state_n = S_WS_RD_EVEN;
      S_WS_RD_EVEN: state_n = S_WS_RD_ODD;
      S_WS_RD_ODD:  state_n = (sc == 6'd63) ? S_WS_LO : S_WS_RD_EVEN;
      S_WS_LO:      state_n = S_WS_DONE;
      S_WS_DONE:    state_n = S_WS_IDLE;
      default:      state_n = S_WS_IDLE;
    endcase
  end

  // FSM: next values of the registered outputs. A write strobe lasts one
  // cycle because we_n returns to 1 unless a write is issued again.
  always_comb begin
    we_n_n = 1'b1;
    done_n = 1'b0;
    addr_n = SRAM_address;
    data_n = SRAM_write_data;
    if (wr_issue) begin
      we_n_n = 1'b0;
      addr_n = wr_addr;
      data_n = {even_pix, cur_pix};
    end
    if (state == S_WS_DONE) done_n = 1'b1;
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_we_n       <= 1'b1;
      WS_done         <= 1'b0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
    end else begin
      SRAM_we_n       <= we_n_n;
      WS_done         <= done_n;
      SRAM_address    <= addr_n;
      SRAM_write_data <= data_n;
    end
  end

  // Sample sequencing and block position tracking.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      sc       <= 6'd0;
      even_pix <= 8'd0;
      pair_idx <= 5'd0;
      pend     <= 1'b0;
      plane    <= PL_Y;
      rb       <= 5'd0;
      cb       <= 6'd0;
    end else begin
      case (state)
        S_WS_IDLE: begin
          pend <= 1'b0;
          if (WS_start) sc <= 6'd0;
        end
        S_WS_RD_EVEN: begin
          sc   <= sc + 6'd1;
          pend <= 1'b0;
        end
        S_WS_RD_ODD: begin
          sc       <= sc + 6'd1;
          even_pix <= cur_pix;
          pair_idx <= sc[5:1];
          pend     <= 1'b1;
        end
        S_WS_LO: pend <= 1'b0;
        S_WS_DONE: begin
          if (cb == c_end) begin
            cb <= 6'd0;
            if (rb == 5'd29) begin
              rb <= 5'd0;
              case (plane)
                PL_Y:    plane <= PL_U;
                PL_U:    plane <= PL_V;
                default: plane <= PL_Y;
              endcase
            end else begin
              rb <= rb + 5'd1;
            end
          end else begin
            cb <= cb + 6'd1;
          end
        end
        default: pend <= 1'b0;
      endcase
    end
  end

`ifdef WS_CLIP_CNT_EN
  // A sample is taken on the bus in RD_ODD (even) and when a write is
  // issued (odd); at most one per cycle.
  logic sample_valid;
  assign sample_valid = (state == S_WS_RD_ODD) || wr_issue;

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn)
      WS_clip_count <= 16'd0;
    else if (sample_valid && cur_clipped && (WS_clip_count != 16'hFFFF))
      WS_clip_count <= WS_clip_count + 16'd1;
  end
`else
  logic unused_clip;
  assign unused_clip = cur_clipped;
`endif

endmodule
